// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - clear-then-triangle draw sequencer with VGA plot-bus mux
// Optional watchdog abort enabled by defining DRAW_SEQ_TIMEOUT_EN.
module draw_sequencer #(
    parameter logic [2:0] CLEAR_COLOUR   = 3'b000,
    parameter int         TIMEOUT_CYCLES = 40000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] diameter,
    output logic       done,
    output logic       err,
    output logic       fs_start,
    input  logic       fs_done,
    input  logic [7:0] fs_vga_x,
    input  logic [6:0] fs_vga_y,
    input  logic       fs_vga_plot,
    output logic       tri_start,
    input  logic       tri_done,
    output logic [2:0] tri_colour,
    output logic [7:0] tri_centre_x,
    output logic [6:0] tri_centre_y,
    output logic [7:0] tri_diameter,
    input  logic [7:0] tri_vga_x,
    input  logic [6:0] tri_vga_y,
    input  logic [2:0] tri_vga_colour,
    input  logic       tri_vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [2:0] {
        IDLE,
        CLR_GO,
        CLR_WAIT,
        TRI_GO,
        TRI_WAIT,
        FIN,
        ERR
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] colour_q, colour_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic [7:0] diam_q, diam_d;

`ifdef DRAW_SEQ_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        wd_expired;

    assign wd_expired = (wd_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            colour_q <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            diam_q   <= '0;
`ifdef DRAW_SEQ_TIMEOUT_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            colour_q <= colour_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            diam_q   <= diam_d;
`ifdef DRAW_SEQ_TIMEOUT_EN
            wd_q     <= wd_d;
`endif
        end
    end

    // GO states deliberately ignore engine done so a done left high by a prior run is not taken.
    always_comb begin
        state_d  = state_q;
        colour_d = colour_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        diam_d   = diam_q;
`ifdef DRAW_SEQ_TIMEOUT_EN
        wd_d     = wd_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    colour_d = colour;
                    cx_d     = centre_x;
                    cy_d     = centre_y;
                    diam_d   = diameter;
                    state_d  = CLR_GO;
                end
            end
            CLR_GO: begin
                state_d = CLR_WAIT;
`ifdef DRAW_SEQ_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            CLR_WAIT: begin
                if (fs_done) begin
                    state_d = TRI_GO;
                end
`ifdef DRAW_SEQ_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d = ERR;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
`endif
            end
            TRI_GO: begin
                state_d = TRI_WAIT;
`ifdef DRAW_SEQ_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            TRI_WAIT: begin
                if (tri_done) begin
                    state_d = FIN;
                end
`ifdef DRAW_SEQ_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d = ERR;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
`endif
            end
            FIN, ERR: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fs_start   = (state_q == CLR_GO) || (state_q == CLR_WAIT);
        tri_start  = (state_q == TRI_GO) || (state_q == TRI_WAIT);
        done       = (state_q == FIN) || (state_q == ERR);
        err        = (state_q == ERR);
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (fs_start) begin
            vga_x      = fs_vga_x;
            vga_y      = fs_vga_y;
            vga_colour = CLEAR_COLOUR;
            vga_plot   = fs_vga_plot;
        end else if (tri_start) begin
            vga_x      = tri_vga_x;
            vga_y      = tri_vga_y;
            vga_colour = tri_vga_colour;
            vga_plot   = tri_vga_plot;
        end
    end

    assign tri_colour   = colour_q;
    assign tri_centre_x = cx_q;
    assign tri_centre_y = cy_q;
    assign tri_diameter = diam_q;

endmodule
